fft_serial_reorder: RTL

//  Downstream neighbour of the serial 8-point hi/lo FFT stage. Takes its serial I/Q output

---
 rtl/fe_fft_pkg.sv | 28 ++
 rtl/fe_pingpong_ram.sv | 30 +++
 rtl/fft_serial_reorder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fe_fft_pkg.sv
// Shared definitions for the FFT reorder path: frame size derivation,
// bit-reversal helper and the write/read FSM state types.
package fe_fft_pkg;

    function automatic int unsigned fft_size(input int unsigned nbw);
        return 32'd1 << nbw;
    endfunction

    function automatic int unsigned bitrev(input int unsigned k, input int unsigned nbits);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < nbits; b++) begin
            r = (r << 1) | ((k >> b) & 32'd1);
        end
        return r;
    endfunction

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fe_pingpong_ram.sv
// Two-bank frame buffer: one write port, one synchronous read port.
// Bank select is the address MSB; contents are never reset.
module fe_pingpong_ram
    import fe_fft_pkg::*;
#(
    parameter int NBW_IN = 9,
    parameter int NBW_FS = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [NBW_FS:0]       wr_addr,
    input  logic [2*NBW_IN-1:0]   wr_data,
    input  logic                  rd_en,
    input  logic [NBW_FS:0]       rd_addr,
    output logic [2*NBW_IN-1:0]   rd_data
);
    localparam int unsigned DEPTH = 2 * fft_size(NBW_FS);

    logic [2*NBW_IN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_serial_reorder.sv
// Reorders bit-reversed serial FFT frames into natural bin order via a ping-pong buffer.
//  state   | meaning
//  W_IDLE  | waiting for a lo-flagged sample to start a frame
//  W_FILL  | storing samples k=1..FFT_SIZE-1 of the current frame
//  R_IDLE  | no full bank at rd_bank
//  R_DRAIN | reading bins of rd_bank in natural order
module fft_serial_reorder
    import fe_fft_pkg::*;
#(
    parameter int NBW_IN = 9,
    parameter int NBW_FS = 3
) (
    input  logic                     clk,
    input  logic                     rst_async_n,
    input  logic                     i_valid,
    input  logic                     i_hi_lo_flag,
    input  logic signed [NBW_IN-1:0] i_data [1:0],
    output logic                     o_valid,
    output logic                     o_sof,
    output logic                     o_eof,
    output logic [NBW_FS-1:0]        o_bin,
    output logic signed [NBW_IN-1:0] o_data [1:0],
    output logic                     o_err
);
    localparam int unsigned FFT_SIZE = fft_size(NBW_FS);
    localparam logic [NBW_FS-1:0] K_LAST = NBW_FS'(FFT_SIZE - 1);

    wr_state_t           w_state;
    rd_state_t           r_state;
    logic [NBW_FS-1:0]   wr_k, rd_cnt, rd_bin_q, w_slot;
    logic                wr_bank, rd_bank, rd_valid_q;
    logic [1:0]          bank_full;
    logic                w_start, w_write, w_done, w_abort, rd_go, rd_last;
    logic [2*NBW_IN-1:0] ram_q;

    always_comb begin
        w_start = 1'b0;
        w_write = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                w_start = i_valid && !i_hi_lo_flag;
                w_abort = i_valid && i_hi_lo_flag;
            end
            W_FILL: begin
                if (!i_valid) begin
                    w_abort = 1'b1;
                end else if (i_hi_lo_flag != wr_k[NBW_FS-1]) begin
                    // a premature lo sample is taken as k=0 of a fresh frame
                    w_abort = 1'b1;
                    w_start = !i_hi_lo_flag;
                end else begin
                    w_write = 1'b1;
                    w_done  = (wr_k == K_LAST);
                end
            end
        endcase
        w_write = w_write || w_start;
        w_slot  = w_start ? NBW_FS'(bitrev(32'd0, NBW_FS))
                          : NBW_FS'(bitrev(32'(wr_k), NBW_FS));
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            w_state <= W_IDLE;
            wr_k    <= '0;
            wr_bank <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_err <= w_abort;
            if (w_done) begin
                w_state <= W_IDLE;
                wr_k    <= '0;
                wr_bank <= ~wr_bank;
            end else if (w_start) begin
                w_state <= W_FILL;
                wr_k    <= NBW_FS'(1);
            end else if (w_abort) begin
                w_state <= W_IDLE;
                wr_k    <= '0;
            end else if (w_write) begin
                wr_k <= wr_k + 1'b1;
            end
        end
    end

    assign rd_go   = (r_state == R_DRAIN) || bank_full[rd_bank];
    assign rd_last = rd_go && (rd_cnt == K_LAST);

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_state    <= R_IDLE;
            rd_cnt     <= '0;
            rd_bank    <= 1'b0;
            bank_full  <= 2'b00;
            rd_valid_q <= 1'b0;
            rd_bin_q   <= '0;
        end else begin
            bank_full  <= (bank_full | ({1'b0, w_done} << wr_bank))
                        & ~({1'b0, rd_last} << rd_bank);
            rd_valid_q <= rd_go;
            rd_bin_q   <= rd_cnt;
            unique case (r_state)
                R_IDLE: begin
                    if (rd_go) begin
                        r_state <= R_DRAIN;
                        rd_cnt  <= rd_cnt + 1'b1;
                    end
                end
                R_DRAIN: begin
                    if (rd_last) begin
                        rd_cnt  <= '0;
                        rd_bank <= ~rd_bank;
                        r_state <= bank_full[~rd_bank] ? R_DRAIN : R_IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    fe_pingpong_ram #(
        .NBW_IN (NBW_IN),
        .NBW_FS (NBW_FS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_write),
        .wr_addr ({wr_bank, w_slot}),
        .wr_data ({i_data[1], i_data[0]}),
        .rd_en   (rd_go),
        .rd_addr ({rd_bank, rd_cnt}),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            o_valid   <= 1'b0;
            o_sof     <= 1'b0;
            o_eof     <= 1'b0;
            o_bin     <= '0;
            o_data[0] <= '0;
            o_data[1] <= '0;
        end else begin
            o_valid <= rd_valid_q;
            o_sof   <= rd_valid_q && (rd_bin_q == '0);
            o_eof   <= rd_valid_q && (rd_bin_q == K_LAST);
            if (rd_valid_q) begin
                o_bin     <= rd_bin_q;
                o_data[0] <= ram_q[NBW_IN-1:0];
                o_data[1] <= ram_q[2*NBW_IN-1:NBW_IN];
            end
        end
    end

    a_no_overfill: assert property (@(posedge clk) disable iff (!rst_async_n)
        w_start |-> !bank_full[wr_bank]);

endmodule
